// File: rtl/ascon_fsm_ctrl.sv
// ascon_fsm_ctrl: control FSM for one ASCON-128 authenticated encryption.
// Sequences init, AD absorption, PT encryption and finalisation rounds.
module ascon_fsm_ctrl (
  input  logic       clock_i,
  input  logic       reset_i,
  input  logic       start_i,
  input  logic       data_valid_i,
  input  logic       data_last_i,
  output logic [3:0] round_o,
  output logic       selectionp_o,
  output logic       enable_o,
  output logic       en_xor_data_begin_o,
  output logic       en_xor_key_begin_o,
  output logic       en_xor_key_end_o,
  output logic       en_xor_lsb_end_o,
  output logic       en_cipher_o,
  output logic       en_tag_o,
  output logic       data_ready_o,
  output logic       busy_o,
  output logic       done_o
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_INIT    = 3'd1;
  localparam logic [2:0] S_WAIT_AD = 3'd2;
  localparam logic [2:0] S_AD      = 3'd3;
  localparam logic [2:0] S_WAIT_PT = 3'd4;
  localparam logic [2:0] S_PT      = 3'd5;
  localparam logic [2:0] S_FINAL   = 3'd6;
  localparam logic [2:0] S_DONE    = 3'd7;

  // p^a runs 0..11, p^b runs 6..11; both finish on round 11
  localparam logic [3:0] RND_FIRST_A = 4'd0;
  localparam logic [3:0] RND_FIRST_B = 4'd6;
  localparam logic [3:0] RND_LAST    = 4'd11;

  logic [2:0] state_q, state_d;
  logic [3:0] rnd_q, rnd_d;
  logic       last_q, last_d;

  logic rnd_first_a;
  logic rnd_first_b;
  logic rnd_last;
  logic rnd_bad;

  assign rnd_first_a = (rnd_q == RND_FIRST_A);
  assign rnd_first_b = (rnd_q == RND_FIRST_B);
  assign rnd_last    = (rnd_q == RND_LAST);
  assign rnd_bad     = (rnd_q > RND_LAST);

  // state, round counter and last-block flag registers
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_IDLE;
      rnd_q   <= 4'd0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rnd_q   <= rnd_d;
      last_q  <= last_d;
    end
  end

  // next-state logic; counter holds at 11 while waiting for data
  always_comb begin
    state_d = state_q;
    rnd_d   = rnd_q;
    last_d  = last_q;
    unique case (state_q)
      S_IDLE: begin
        rnd_d = 4'd0;
        if (start_i) begin
          state_d = S_INIT;
        end
      end
      S_INIT, S_AD, S_PT, S_FINAL: begin
        if (rnd_bad) begin
          state_d = S_IDLE;
          rnd_d   = 4'd0;
        end else if (!rnd_last) begin
          rnd_d = rnd_q + 4'd1;
        end else begin
          unique case (state_q)
            S_INIT:  state_d = S_WAIT_AD;
            S_AD:    state_d = last_q ? S_WAIT_PT : S_WAIT_AD;
            S_PT:    state_d = S_WAIT_PT;
            default: state_d = S_DONE;
          endcase
        end
      end
      S_WAIT_AD: begin
        if (data_valid_i) begin
          last_d  = data_last_i;
          state_d = S_AD;
          rnd_d   = RND_FIRST_B;
        end
      end
      S_WAIT_PT: begin
        if (data_valid_i) begin
          last_d = data_last_i;
          if (data_last_i) begin
            state_d = S_FINAL;
            rnd_d   = RND_FIRST_A;
          end else begin
            state_d = S_PT;
            rnd_d   = RND_FIRST_B;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        rnd_d   = 4'd0;
      end
      default: begin
        state_d = S_IDLE;
        rnd_d   = 4'd0;
      end
    endcase
  end

  // Moore output decode from state and round counter
  always_comb begin
    selectionp_o        = 1'b0;
    enable_o            = 1'b0;
    en_xor_data_begin_o = 1'b0;
    en_xor_key_begin_o  = 1'b0;
    en_xor_key_end_o    = 1'b0;
    en_xor_lsb_end_o    = 1'b0;
    en_cipher_o         = 1'b0;
    en_tag_o            = 1'b0;
    data_ready_o        = 1'b0;
    busy_o              = 1'b0;
    done_o              = 1'b0;
    unique case (state_q)
      S_IDLE: begin
      end
      S_INIT: begin
        busy_o           = 1'b1;
        enable_o         = 1'b1;
        selectionp_o     = !rnd_first_a;
        en_xor_key_end_o = rnd_last;
      end
      S_WAIT_AD, S_WAIT_PT: begin
        busy_o       = 1'b1;
        selectionp_o = 1'b1;
        data_ready_o = 1'b1;
      end
      S_AD: begin
        busy_o              = 1'b1;
        selectionp_o        = 1'b1;
        enable_o            = 1'b1;
        en_xor_data_begin_o = rnd_first_b;
        en_xor_lsb_end_o    = rnd_last & last_q;
      end
      S_PT: begin
        busy_o              = 1'b1;
        selectionp_o        = 1'b1;
        enable_o            = 1'b1;
        en_xor_data_begin_o = rnd_first_b;
        en_cipher_o         = rnd_first_b;
      end
      S_FINAL: begin
        busy_o              = 1'b1;
        selectionp_o        = 1'b1;
        enable_o            = 1'b1;
        en_xor_data_begin_o = rnd_first_a;
        en_xor_key_begin_o  = rnd_first_a;
        en_cipher_o         = rnd_first_a;
        en_xor_key_end_o    = rnd_last;
        en_tag_o            = rnd_last;
      end
      S_DONE: begin
        busy_o       = 1'b1;
        selectionp_o = 1'b1;
        done_o       = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign round_o = rnd_q;

endmodule

// File: tb/tb_ascon_fsm_ctrl.sv
// tb_ascon_fsm_ctrl: scoreboard bench for the ASCON control FSM.
// Expected per-cycle output vectors are queued with the stimulus.
module tb_ascon_fsm_ctrl;

  typedef logic [14:0] vec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       valid;
  logic       last;
  logic [3:0] round_o;
  logic       sel_o, en_o, xdb_o, xkb_o, xke_o, xle_o;
  logic       ci_o, tag_o, rdy_o, busy_o, done_o;

  always #5 clk = ~clk;

  ascon_fsm_ctrl dut (
    .clock_i             (clk),
    .reset_i             (rst),
    .start_i             (start),
    .data_valid_i        (valid),
    .data_last_i         (last),
    .round_o             (round_o),
    .selectionp_o        (sel_o),
    .enable_o            (en_o),
    .en_xor_data_begin_o (xdb_o),
    .en_xor_key_begin_o  (xkb_o),
    .en_xor_key_end_o    (xke_o),
    .en_xor_lsb_end_o    (xle_o),
    .en_cipher_o         (ci_o),
    .en_tag_o            (tag_o),
    .data_ready_o        (rdy_o),
    .busy_o              (busy_o),
    .done_o              (done_o)
  );

  vec_t obs;
  assign obs = {round_o, sel_o, en_o, xdb_o, xkb_o, xke_o,
                xle_o, ci_o, tag_o, rdy_o, busy_o, done_o};

  logic [2:0] stim_q[$];
  vec_t       exp_q[$];

  int n_cmp = 0;
  int n_bad = 0;
  int n_xdb_ad = 0;
  int n_lsb = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, want);
    end
  endtask

  function automatic vec_t mk(
    input logic [3:0] r, input logic sel, input logic en,
    input logic xdb, input logic xkb, input logic xke,
    input logic xle, input logic ci, input logic tg,
    input logic rdy, input logic bsy, input logic dn);
    return {r, sel, en, xdb, xkb, xke, xle, ci, tg, rdy, bsy, dn};
  endfunction

  task automatic push(input logic [2:0] s, input vec_t e);
    stim_q.push_back(s);
    exp_q.push_back(e);
  endtask

  // Build one full run: stimulus {start,valid,last} and expected outputs
  task automatic gen(input int n_ad, input int n_pt,
                     input int stall, input bit pulse);
    logic [1:0] rn;
    logic       lst;
    vec_t       wv;
    wv = mk(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
    rn = 2'($urandom_range(0, 3));
    push({1'b1, rn}, '0);
    for (int r = 0; r < 12; r++) begin
      rn = 2'($urandom_range(0, 3));
      push({1'b0, rn},
           mk(4'(r), r != 0, 1, 0, 0, r == 11, 0, 0, 0, 0, 1, 0));
    end
    for (int a = 0; a < n_ad; a++) begin
      lst = (a == n_ad - 1);
      push({2'b01, lst}, wv);
      for (int r = 6; r < 12; r++) begin
        rn = 2'($urandom_range(0, 3));
        push({1'b0, rn}, mk(4'(r), 1, 1, r == 6, 0, 0,
                            (r == 11) && lst, 0, 0, 0, 1, 0));
      end
    end
    for (int p = 0; p < n_pt; p++) begin
      lst = (p == n_pt - 1);
      for (int s = 0; s < stall; s++) begin
        rn = 2'($urandom_range(0, 3));
        push({2'b00, rn[0]}, wv);
      end
      push({2'b01, lst}, wv);
      if (!lst) begin
        for (int r = 6; r < 12; r++) begin
          rn = 2'($urandom_range(0, 3));
          push({pulse, rn}, mk(4'(r), 1, 1, r == 6, 0, 0, 0,
                               r == 6, 0, 0, 1, 0));
        end
      end
    end
    for (int r = 0; r < 12; r++) begin
      rn = 2'($urandom_range(0, 3));
      push({1'b0, rn}, mk(4'(r), 1, 1, r == 0, r == 0, r == 11, 0,
                          r == 0, r == 11, 0, 1, 0));
    end
    rn = 2'($urandom_range(0, 3));
    push({pulse, rn}, mk(4'd11, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    push(3'b000, '0);
    push(3'b000, '0);
  endtask

  // Drain the scoreboard: one entry driven and compared per cycle
  task automatic run_sb(input string name);
    logic [2:0] s;
    vec_t       e;
    int         i;
    i = 0;
    while (exp_q.size() > 0) begin
      s = stim_q.pop_front();
      e = exp_q.pop_front();
      @(negedge clk);
      {start, valid, last} = s;
      chk($sformatf("%s_c%0d", name, i), 32'(obs), 32'(e));
      if (obs[8] && !obs[4]) n_xdb_ad++;
      if (obs[5]) n_lsb++;
      i++;
    end
    start = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
  endtask

  initial begin
    bit found;
    rst   = 1'b1;
    start = 1'b0;
    valid = 1'b0;
    last  = 1'b0;
    repeat (2) @(negedge clk);
    chk("reset_state", 32'(obs), 32'd0);
    rst = 1'b0;

    // reset in the middle of INIT
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (round_o == 4'd5 && en_o) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    chk("init_r5_reached", 32'(found), 32'd1);
    rst = 1'b1;
    #1;
    chk("reset_mid_init", 32'(obs), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // nominal: restart after reset, 1 AD, PT last = 0,0,1
    gen(1, 3, 0, 1'b0);
    run_sb("nominal");

    // three AD blocks, last only on the third
    n_xdb_ad = 0;
    n_lsb = 0;
    gen(3, 2, 0, 1'b0);
    run_sb("multi_ad");
    chk("ad_xdb_pulses", 32'(n_xdb_ad), 32'd3);
    chk("lsb_end_pulses", 32'(n_lsb), 32'd1);

    // stalled PT handshake, 10 idle valid cycles per block
    gen(1, 2, 10, 1'b0);
    run_sb("stall");

    // start pulsed during PT and DONE
    gen(2, 3, 0, 1'b1);
    run_sb("start_ign");

    // single PT block goes straight to FINAL
    gen(1, 1, 0, 1'b0);
    run_sb("single_pt");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
